table_mp: RTL and testbench

- Next-generation multi-port lookup table: WR_PORTS independent write ports and RD_PORTS independent read ports, each with its own valid.
- Adds per-entry valid bits, deterministic same-index write priority, optional write-to-read bypass, configurable read latency, and a sequential clear engine.
- Sits wherever an indexed state table is needed, for example flow or tag tables feeding downstream pipelines.

---
 rtl/table_pkg.sv | 26 ++
 rtl/table_wr_resolve.sv | 53 +++++
 rtl/table_mp.sv | 188 ++++++++++++++++++
 tb/tb_table_mp.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/table_pkg.sv
// Shared types and elaboration helpers for the multi-port lookup table.
// Covers index sizing, port slicing, the clear-FSM states and the read-latency check.
package table_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    function automatic int idx_width(input int entries);
        return (entries < 2) ? 1 : $clog2(entries);
    endfunction

    // Low bit of port p inside a flattened bus of per-port fields.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

    function automatic bit rd_latency_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/table_wr_resolve.sv
// Combinational write-port resolution: per-entry enable/data and per-read-port bypass.
// Ports are scanned in ascending order, so the highest-numbered matching port wins.
module table_wr_resolve
    import table_pkg::*;
#(
    parameter int TABLE_SIZE = 32,
    parameter int DATA_WIDTH = 8,
    parameter int WR_PORTS   = 2,
    parameter int RD_PORTS   = 2,
    parameter int IW         = 5
) (
    input  logic [WR_PORTS-1:0]                     wr_en,
    input  logic [WR_PORTS*IW-1:0]                  wr_index,
    input  logic [WR_PORTS*DATA_WIDTH-1:0]          wr_data,
    input  logic [RD_PORTS*IW-1:0]                  rd_index,
    output logic [TABLE_SIZE-1:0]                   ent_we,
    output logic [TABLE_SIZE-1:0][DATA_WIDTH-1:0]   ent_wdata,
    output logic [RD_PORTS-1:0]                     byp_hit,
    output logic [RD_PORTS-1:0][DATA_WIDTH-1:0]     byp_data
);

    localparam logic [IW:0] SIZE_EXT = (IW + 1)'(TABLE_SIZE);

    // Out-of-range indices never match an entry number, so those writes fall away here.
    always_comb begin
        ent_we    = '0;
        ent_wdata = '0;
        for (int e = 0; e < TABLE_SIZE; e++) begin
            for (int p = 0; p < WR_PORTS; p++) begin
                if (wr_en[p] && (wr_index[slice_lo(p, IW) +: IW] == IW'(e))) begin
                    ent_we[e]    = 1'b1;
                    ent_wdata[e] = wr_data[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        byp_hit  = '0;
        byp_data = '0;
        for (int q = 0; q < RD_PORTS; q++) begin
            for (int p = 0; p < WR_PORTS; p++) begin
                if (wr_en[p]
                    && (wr_index[slice_lo(p, IW) +: IW] == rd_index[slice_lo(q, IW) +: IW])
                    && ({1'b0, rd_index[slice_lo(q, IW) +: IW]} < SIZE_EXT)) begin
                    byp_hit[q]  = 1'b1;
                    byp_data[q] = wr_data[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/table_mp.sv
// Multi-port lookup table with per-entry valid bits, write bypass, 1/2-cycle reads
// and a sequential clear sweep that erases one entry per cycle.
module table_mp
    import table_pkg::*;
#(
    parameter int TABLE_SIZE = 32,
    parameter int DATA_WIDTH = 8,
    parameter int WR_PORTS   = 2,
    parameter int RD_PORTS   = 2,
    parameter int RD_LATENCY = 1,
    parameter int BYPASS     = 1,
    localparam int IW        = idx_width(TABLE_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr_req,
    output logic                             busy,
    input  logic [WR_PORTS-1:0]              wr_valid,
    output logic                             wr_ready,
    input  logic [WR_PORTS*IW-1:0]           wr_index,
    input  logic [WR_PORTS*DATA_WIDTH-1:0]   wr_data,
    input  logic [RD_PORTS-1:0]              rd_valid,
    input  logic [RD_PORTS*IW-1:0]           rd_index,
    output logic [RD_PORTS-1:0]              rd_out_valid,
    output logic [RD_PORTS-1:0]              rd_hit,
    output logic [RD_PORTS*DATA_WIDTH-1:0]   rd_data,
    output clr_state_t                       dbg_state
);

    localparam logic [IW:0]   SIZE_EXT = (IW + 1)'(TABLE_SIZE);
    localparam logic [IW-1:0] LAST_IDX = IW'(TABLE_SIZE - 1);

    if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
        $error("table_mp: RD_LATENCY must be 1 or 2");
    end

    clr_state_t                               state;
    logic [IW-1:0]                            clr_cnt;
    logic [DATA_WIDTH-1:0]                    mem [TABLE_SIZE];
    logic [TABLE_SIZE-1:0]                    ent_valid;
    logic [WR_PORTS-1:0]                      wr_en;
    logic [TABLE_SIZE-1:0]                    ent_we;
    logic [TABLE_SIZE-1:0][DATA_WIDTH-1:0]    ent_wdata;
    logic [RD_PORTS-1:0]                      byp_hit;
    logic [RD_PORTS-1:0][DATA_WIDTH-1:0]      byp_data;

    // Handshake: a write on port p transfers on a rising edge where wr_valid[p] && wr_ready;
    // wr_ready is shared by all ports and is low for the whole clear sweep. Reads have no
    // back-pressure: every rd_valid[q] produces rd_out_valid[q] RD_LATENCY edges later.
    assign wr_ready  = ~busy;
    assign wr_en     = wr_valid & {WR_PORTS{wr_ready}};
    assign dbg_state = state;

    table_wr_resolve #(
        .TABLE_SIZE (TABLE_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .WR_PORTS   (WR_PORTS),
        .RD_PORTS   (RD_PORTS),
        .IW         (IW)
    ) u_resolve (
        .wr_en     (wr_en),
        .wr_index  (wr_index),
        .wr_data   (wr_data),
        .rd_index  (rd_index),
        .ent_we    (ent_we),
        .ent_wdata (ent_wdata),
        .byp_hit   (byp_hit),
        .byp_data  (byp_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            clr_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == LAST_IDX) begin
                        state   <= IDLE;
                        clr_cnt <= '0;
                        busy    <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < TABLE_SIZE; e++) begin
                mem[e] <= '0;
            end
            ent_valid <= '0;
        end else begin
            for (int e = 0; e < TABLE_SIZE; e++) begin
                if (state == CLEAR && clr_cnt == IW'(e)) begin
                    mem[e]       <= '0;
                    ent_valid[e] <= 1'b0;
                end else if (ent_we[e]) begin
                    mem[e]       <= ent_wdata[e];
                    ent_valid[e] <= 1'b1;
                end
            end
        end
    end

    logic [RD_PORTS-1:0]              nxt_valid;
    logic [RD_PORTS-1:0]              nxt_hit;
    logic [RD_PORTS*DATA_WIDTH-1:0]   nxt_data;

    // Reads during the sweep report a miss so consumers never see half-cleared contents.
    always_comb begin
        logic [IW-1:0] idx;
        nxt_valid = rd_valid;
        nxt_hit   = '0;
        nxt_data  = '0;
        idx       = '0;
        for (int q = 0; q < RD_PORTS; q++) begin
            idx = rd_index[slice_lo(q, IW) +: IW];
            if (rd_valid[q] && state == IDLE) begin
                if (BYPASS != 0 && byp_hit[q]) begin
                    nxt_hit[q] = 1'b1;
                    nxt_data[slice_lo(q, DATA_WIDTH) +: DATA_WIDTH] = byp_data[q];
                end else if (({1'b0, idx} < SIZE_EXT) && ent_valid[idx]) begin
                    nxt_hit[q] = 1'b1;
                    nxt_data[slice_lo(q, DATA_WIDTH) +: DATA_WIDTH] = mem[idx];
                end
            end
        end
    end

    logic [RD_PORTS-1:0]              s1_valid;
    logic [RD_PORTS-1:0]              s1_hit;
    logic [RD_PORTS*DATA_WIDTH-1:0]   s1_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= '0;
            s1_hit   <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= nxt_valid;
            s1_hit   <= nxt_hit;
            s1_data  <= nxt_data;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [RD_PORTS-1:0]              s2_valid;
        logic [RD_PORTS-1:0]              s2_hit;
        logic [RD_PORTS*DATA_WIDTH-1:0]   s2_data;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_valid <= '0;
                s2_hit   <= '0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                s2_hit   <= s1_hit;
                s2_data  <= s1_data;
            end
        end

        assign rd_out_valid = s2_valid;
        assign rd_hit       = s2_hit;
        assign rd_data      = s2_data;
    end else begin : g_lat1
        assign rd_out_valid = s1_valid;
        assign rd_hit       = s1_hit;
        assign rd_data      = s1_data;
    end

endmodule

// File: tb/tb_table_mp.sv
// Bench for table_mp: a bypass/1-cycle instance and a no-bypass/2-cycle instance share stimulus;
// a reference model feeds per-instance expected queues, and each scenario task adds its own checks.
module tb_table_mp;

    localparam int TS = 32;
    localparam int DW = 8;
    localparam int IW = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clr_req;
    logic [1:0]     wr_valid;
    logic [9:0]     wr_index;
    logic [15:0]    wr_data;
    logic [1:0]     rd_valid;
    logic [9:0]     rd_index;

    logic           bp_busy, bp_wr_ready, nb_busy, nb_wr_ready;
    logic [1:0]     bp_rov, bp_hit, nb_rov, nb_hit;
    logic [15:0]    bp_data, nb_data;
    table_pkg::clr_state_t bp_state, nb_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    table_mp #(.RD_LATENCY(1), .BYPASS(1)) u_bp (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(bp_busy),
        .wr_valid(wr_valid), .wr_ready(bp_wr_ready), .wr_index(wr_index), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_index(rd_index), .rd_out_valid(bp_rov), .rd_hit(bp_hit),
        .rd_data(bp_data), .dbg_state(bp_state)
    );

    table_mp #(.RD_LATENCY(2), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(nb_busy),
        .wr_valid(wr_valid), .wr_ready(nb_wr_ready), .wr_index(wr_index), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_index(rd_index), .rd_out_valid(nb_rov), .rd_hit(nb_hit),
        .rd_data(nb_data), .dbg_state(nb_state)
    );

    // ---------------- reference model and scoreboard ----------------
    logic [DW-1:0]  m_data [TS];
    logic           m_valid [TS];
    bit             m_clear;
    int             m_cnt;
    bit             mon_on = 1'b0;
    logic [19:0]    exp_q1[$];
    logic [19:0]    exp_q2[$];

    logic [1:0]     e_v, e_h1, e_h2;
    logic [15:0]    e_d1, e_d2;
    logic [19:0]    exp_w, got_w;
    int             m_idx;

    task automatic model_reset();
        for (int i = 0; i < TS; i++) begin
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
        end
        m_clear = 1'b0;
        m_cnt   = 0;
        exp_q1.delete();
        exp_q2.delete();
    endtask

    always @(posedge clk) begin
        if (mon_on) begin
            e_v = '0; e_h1 = '0; e_h2 = '0; e_d1 = '0; e_d2 = '0;
            for (int q = 0; q < 2; q++) begin
                if (rd_valid[q]) begin
                    e_v[q] = 1'b1;
                    if (!m_clear) begin
                        m_idx = int'(rd_index[q*IW +: IW]);
                        e_h2[q] = m_valid[m_idx];
                        e_d2[q*DW +: DW] = m_valid[m_idx] ? m_data[m_idx] : 8'h00;
                        e_h1[q] = e_h2[q];
                        e_d1[q*DW +: DW] = e_d2[q*DW +: DW];
                        for (int p = 0; p < 2; p++) begin
                            if (wr_valid[p] && wr_index[p*IW +: IW] == rd_index[q*IW +: IW]) begin
                                e_h1[q] = 1'b1;
                                e_d1[q*DW +: DW] = wr_data[p*DW +: DW];
                            end
                        end
                    end
                end
            end
            exp_q1.push_back({e_v, e_h1, e_d1});
            exp_q2.push_back({e_v, e_h2, e_d2});
            if (!m_clear) begin
                for (int p = 0; p < 2; p++) begin
                    if (wr_valid[p]) begin
                        m_data[int'(wr_index[p*IW +: IW])]  = wr_data[p*DW +: DW];
                        m_valid[int'(wr_index[p*IW +: IW])] = 1'b1;
                    end
                end
                if (clr_req) begin
                    m_clear = 1'b1;
                    m_cnt   = 0;
                end
            end else begin
                m_data[m_cnt]  = '0;
                m_valid[m_cnt] = 1'b0;
                if (m_cnt == TS - 1) m_clear = 1'b0;
                else m_cnt++;
            end
            #2;
            exp_w = exp_q1.pop_front();
            got_w = {bp_rov, bp_hit, bp_data};
            n_checks++;
            if (got_w !== exp_w) begin
                n_errors++;
                $display("FAIL sb_read_bypass_lat1: got %h expected %h (t=%0t)", got_w, exp_w, $time);
            end
            if (exp_q2.size() > 1) begin
                exp_w = exp_q2.pop_front();
                got_w = {nb_rov, nb_hit, nb_data};
                n_checks++;
                if (got_w !== exp_w) begin
                    n_errors++;
                    $display("FAIL sb_read_nobypass_lat2: got %h expected %h (t=%0t)", got_w, exp_w, $time);
                end
            end
            n_checks++;
            if ({bp_busy, bp_wr_ready, nb_busy, nb_wr_ready} !== {m_clear, !m_clear, m_clear, !m_clear}) begin
                n_errors++;
                $display("FAIL sb_busy_ready: got %b%b%b%b expected busy=%0d (t=%0t)",
                         bp_busy, bp_wr_ready, nb_busy, nb_wr_ready, m_clear, $time);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        clr_req  = 1'b0;
        wr_valid = '0;
        wr_index = '0;
        wr_data  = '0;
        rd_valid = '0;
        rd_index = '0;
    endtask

    task automatic set_wr(input int p, input int idx, input logic [7:0] d);
        wr_valid[p]          = 1'b1;
        wr_index[p*IW +: IW] = IW'(idx);
        wr_data[p*DW +: DW]  = d;
    endtask

    task automatic set_rd(input int q, input int idx);
        rd_valid[q]          = 1'b1;
        rd_index[q*IW +: IW] = IW'(idx);
    endtask

    task automatic fill_all();
        for (int i = 0; i < TS / 2; i++) begin
            @(negedge clk);
            clear_inputs();
            set_wr(0, 2 * i, 8'($urandom_range(1, 255)));
            set_wr(1, 2 * i + 1, 8'($urandom_range(1, 255)));
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic count_busy(input string name);
        int busy_cycles = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            clear_inputs();
            if (bp_busy) begin
                busy_cycles++;
                n_checks++;
                if (bp_wr_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s_wr_ready_low: got %b required 0", name, bp_wr_ready);
                end
                if (busy_cycles == 10) set_wr(0, 2, 8'hEE);
                if (busy_cycles == 12) clr_req = 1'b1;
                set_rd(1, busy_cycles % TS);
            end else if (busy_cycles > 0) begin
                break;
            end
        end
        n_checks++;
        if (busy_cycles != TS) begin
            n_errors++;
            $display("FAIL %s_busy_cycles: got %0d required %0d", name, busy_cycles, TS);
        end
    endtask

    task automatic read_all_expect_miss(input string name);
        for (int i = 0; i <= TS / 2; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if ({bp_rov, bp_hit, bp_data} !== {2'b11, 2'b00, 16'h0000}) begin
                    n_errors++;
                    $display("FAIL %s_miss: got rov=%b hit=%b data=%h required 11/00/0000",
                             name, bp_rov, bp_hit, bp_data);
                end
            end
            clear_inputs();
            if (i < TS / 2) begin
                set_rd(0, 2 * i);
                set_rd(1, 2 * i + 1);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        mon_on = 1'b0;
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bp_busy, bp_wr_ready, bp_rov, bp_hit, bp_data} !== {1'b0, 1'b1, 2'b00, 2'b00, 16'h0000}) begin
            n_errors++;
            $display("FAIL reset_bp: got busy=%b rdy=%b rov=%b hit=%b data=%h required 0/1/00/00/0000",
                     bp_busy, bp_wr_ready, bp_rov, bp_hit, bp_data);
        end
        n_checks++;
        if ({nb_busy, nb_wr_ready, nb_rov, nb_hit, nb_data} !== {1'b0, 1'b1, 2'b00, 2'b00, 16'h0000}) begin
            n_errors++;
            $display("FAIL reset_nb: got busy=%b rdy=%b rov=%b hit=%b data=%h required 0/1/00/00/0000",
                     nb_busy, nb_wr_ready, nb_rov, nb_hit, nb_data);
        end
        n_checks++;
        if (bp_state !== table_pkg::IDLE) begin
            n_errors++;
            $display("FAIL reset_state: got %0d required IDLE", bp_state);
        end
        model_reset();
        rst = 1'b0;
        mon_on = 1'b1;
    endtask

    task automatic test_read_empty();
        @(negedge clk);
        clear_inputs();
        set_rd(0, 5);
        @(negedge clk);
        clear_inputs();
        n_checks++;
        if ({bp_rov[0], bp_hit[0], bp_data[7:0]} !== {1'b1, 1'b0, 8'h00}) begin
            n_errors++;
            $display("FAIL read_empty_lat1: got rov=%b hit=%b data=%h required 1/0/00",
                     bp_rov[0], bp_hit[0], bp_data[7:0]);
        end
        @(negedge clk);
        n_checks++;
        if ({nb_rov[0], nb_hit[0], nb_data[7:0]} !== {1'b1, 1'b0, 8'h00}) begin
            n_errors++;
            $display("FAIL read_empty_lat2: got rov=%b hit=%b data=%h required 1/0/00",
                     nb_rov[0], nb_hit[0], nb_data[7:0]);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        clear_inputs();
        set_wr(0, 3, 8'hA5);
        set_wr(1, 7, 8'h5A);
        @(negedge clk);
        clear_inputs();
        set_rd(0, 3);
        set_rd(1, 7);
        @(negedge clk);
        clear_inputs();
        n_checks++;
        if ({bp_rov, bp_hit, bp_data} !== {2'b11, 2'b11, 16'h5AA5}) begin
            n_errors++;
            $display("FAIL write_read_lat1: got rov=%b hit=%b data=%h required 11/11/5aa5", bp_rov, bp_hit, bp_data);
        end
        @(negedge clk);
        n_checks++;
        if ({nb_rov, nb_hit, nb_data} !== {2'b11, 2'b11, 16'h5AA5}) begin
            n_errors++;
            $display("FAIL write_read_lat2: got rov=%b hit=%b data=%h required 11/11/5aa5", nb_rov, nb_hit, nb_data);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        clear_inputs();
        set_wr(0, 4, 8'h11);
        set_wr(1, 4, 8'h22);
        @(negedge clk);
        clear_inputs();
        set_rd(0, 4);
        @(negedge clk);
        clear_inputs();
        n_checks++;
        if ({bp_hit[0], bp_data[7:0]} !== {1'b1, 8'h22}) begin
            n_errors++;
            $display("FAIL collision: got hit=%b data=%h required 1/22", bp_hit[0], bp_data[7:0]);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        clear_inputs();
        set_wr(0, 9, 8'h3C);
        set_rd(0, 9);
        @(negedge clk);
        clear_inputs();
        set_wr(0, 12, 8'h44);
        set_wr(1, 12, 8'h88);
        set_rd(1, 12);
        n_checks++;
        if ({bp_rov[0], bp_hit[0], bp_data[7:0]} !== {1'b1, 1'b1, 8'h3C}) begin
            n_errors++;
            $display("FAIL bypass_on: got rov=%b hit=%b data=%h required 1/1/3c", bp_rov[0], bp_hit[0], bp_data[7:0]);
        end
        @(negedge clk);
        clear_inputs();
        set_rd(0, 9);
        n_checks++;
        if ({nb_rov[0], nb_hit[0], nb_data[7:0]} !== {1'b1, 1'b0, 8'h00}) begin
            n_errors++;
            $display("FAIL bypass_off: got rov=%b hit=%b data=%h required 1/0/00", nb_rov[0], nb_hit[0], nb_data[7:0]);
        end
        n_checks++;
        if ({bp_hit[1], bp_data[15:8]} !== {1'b1, 8'h88}) begin
            n_errors++;
            $display("FAIL bypass_priority: got hit=%b data=%h required 1/88", bp_hit[1], bp_data[15:8]);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_clear();
        fill_all();
        @(negedge clk);
        clear_inputs();
        clr_req = 1'b1;
        set_wr(1, 0, 8'h77);
        count_busy("clear");
        read_all_expect_miss("after_clear");
    endtask

    task automatic test_reset_mid_clear();
        fill_all();
        @(negedge clk);
        clear_inputs();
        clr_req = 1'b1;
        repeat (10) begin
            @(negedge clk);
            clear_inputs();
        end
        mon_on = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bp_busy, bp_wr_ready, bp_rov, nb_busy, nb_rov} !== {1'b0, 1'b1, 2'b00, 1'b0, 2'b00}) begin
            n_errors++;
            $display("FAIL mid_clear_reset: got busy=%b rdy=%b rov=%b nb_busy=%b nb_rov=%b required 0/1/00/0/00",
                     bp_busy, bp_wr_ready, bp_rov, nb_busy, nb_rov);
        end
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        mon_on = 1'b1;
        read_all_expect_miss("after_reset");
        @(negedge clk);
        clear_inputs();
        clr_req = 1'b1;
        count_busy("reclear");
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            clear_inputs();
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 1) == 1) set_wr(p, $urandom_range(0, TS - 1), 8'($urandom_range(0, 255)));
                if ($urandom_range(0, 1) == 1) set_rd(p, $urandom_range(0, TS - 1));
            end
            if ($urandom_range(0, 60) == 0) clr_req = 1'b1;
        end
        repeat (40) begin
            @(negedge clk);
            clear_inputs();
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_read_empty();
        test_write_read();
        test_collision();
        test_bypass();
        test_clear();
        test_reset_mid_clear();
        test_random();
        repeat (3) @(negedge clk);
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
